// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register carrying a data and a control bundle with valid/ready,
// stall and flush. SKID=1 adds a second entry so in_ready comes straight from a flop.
module pipe_stage_reg #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        count
);

    logic              eff_ready_s;
    logic              xfer_in_s;
    logic              xfer_out_s;

    logic              main_valid_q;
    logic              main_valid_d;
    logic [DATA_W-1:0] main_data_q;
    logic [DATA_W-1:0] main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [CTRL_W-1:0] main_ctrl_d;

    // Stall looks exactly like a downstream that is not ready.
    assign eff_ready_s = out_ready & ~stall;
    assign xfer_out_s  = main_valid_q & eff_ready_s;

    // Killed or empty slots never present live control bits downstream.
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q & {CTRL_W{main_valid_q}};

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_valid_q;
            logic              skid_valid_d;
            logic [DATA_W-1:0] skid_data_q;
            logic [DATA_W-1:0] skid_data_d;
            logic [CTRL_W-1:0] skid_ctrl_q;
            logic [CTRL_W-1:0] skid_ctrl_d;
            logic              in_ready_q;
            logic              in_ready_d;

            assign xfer_in_s = in_valid & in_ready_q;
            assign in_ready  = in_ready_q;
            assign count     = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

            // Next-state for the main/skid pair; the skid only fills when main cannot drain.
            always_comb begin
                main_valid_d = main_valid_q;
                main_data_d  = main_data_q;
                main_ctrl_d  = main_ctrl_q;
                skid_valid_d = skid_valid_q;
                skid_data_d  = skid_data_q;
                skid_ctrl_d  = skid_ctrl_q;
                if (flush) begin
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end else begin
                    case ({main_valid_q, skid_valid_q})
                        2'b00: begin
                            if (xfer_in_s) begin
                                main_valid_d = 1'b1;
                                main_data_d  = in_data;
                                main_ctrl_d  = in_ctrl;
                            end else begin
                                main_valid_d = 1'b0;
                            end
                        end
                        2'b10: begin
                            if (xfer_in_s && xfer_out_s) begin
                                main_data_d = in_data;
                                main_ctrl_d = in_ctrl;
                            end else if (xfer_out_s) begin
                                main_valid_d = 1'b0;
                            end else if (xfer_in_s) begin
                                skid_valid_d = 1'b1;
                                skid_data_d  = in_data;
                                skid_ctrl_d  = in_ctrl;
                            end else begin
                                main_valid_d = 1'b1;
                            end
                        end
                        2'b11: begin
                            if (xfer_out_s) begin
                                main_data_d  = skid_data_q;
                                main_ctrl_d  = skid_ctrl_q;
                                skid_valid_d = 1'b0;
                            end else begin
                                skid_valid_d = 1'b1;
                            end
                        end
                        default: begin
                            // Skid-only is unreachable; drop it rather than reorder.
                            main_valid_d = 1'b0;
                            skid_valid_d = 1'b0;
                        end
                    endcase
                end
                in_ready_d = ~(main_valid_d & skid_valid_d);
            end

            // State registers for the two-entry variant.
            always_ff @(posedge clk) begin
                if (rst) begin
                    main_valid_q <= 1'b0;
                    main_data_q  <= {DATA_W{1'b0}};
                    main_ctrl_q  <= {CTRL_W{1'b0}};
                    skid_valid_q <= 1'b0;
                    skid_data_q  <= {DATA_W{1'b0}};
                    skid_ctrl_q  <= {CTRL_W{1'b0}};
                    in_ready_q   <= 1'b1;
                end else begin
                    main_valid_q <= main_valid_d;
                    main_data_q  <= main_data_d;
                    main_ctrl_q  <= main_ctrl_d;
                    skid_valid_q <= skid_valid_d;
                    skid_data_q  <= skid_data_d;
                    skid_ctrl_q  <= skid_ctrl_d;
                    in_ready_q   <= in_ready_d;
                end
            end
        end else begin : g_single
            assign in_ready  = ~main_valid_q | eff_ready_s;
            assign xfer_in_s = in_valid & in_ready;
            assign count     = {1'b0, main_valid_q};

            // Next-state for the single register; a new entry replaces a departing one.
            always_comb begin
                main_valid_d = main_valid_q;
                main_data_d  = main_data_q;
                main_ctrl_d  = main_ctrl_q;
                if (flush) begin
                    main_valid_d = 1'b0;
                end else if (xfer_in_s) begin
                    main_valid_d = 1'b1;
                    main_data_d  = in_data;
                    main_ctrl_d  = in_ctrl;
                end else if (xfer_out_s) begin
                    main_valid_d = 1'b0;
                end else begin
                    main_valid_d = main_valid_q;
                end
            end

            // State registers for the single-entry variant.
            always_ff @(posedge clk) begin
                if (rst) begin
                    main_valid_q <= 1'b0;
                    main_data_q  <= {DATA_W{1'b0}};
                    main_ctrl_q  <= {CTRL_W{1'b0}};
                end else begin
                    main_valid_q <= main_valid_d;
                    main_data_q  <= main_data_d;
                    main_ctrl_q  <= main_ctrl_d;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a SKID=1 and a SKID=0 instance with the same stimulus and checks both
// against FIFO-queue reference models of capacity 2 and 1.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [15:0] d;
        logic [7:0]  c;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_ready;

    logic        in_ready1;
    logic        out_valid1;
    logic [15:0] out_data1;
    logic [7:0]  out_ctrl1;
    logic [1:0]  count1;

    logic        in_ready0;
    logic        out_valid0;
    logic [15:0] out_data0;
    logic [7:0]  out_ctrl0;
    logic [1:0]  count0;

    int   checks = 0;
    int   errors = 0;
    ent_t q1[$];
    ent_t q0[$];
    logic exp_rdy1;
    logic exp_rdy0;

    pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_ctrl(out_ctrl1), .count(count1)
    );

    pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_ctrl(out_ctrl0), .count(count0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare both DUTs with the queue models; in_ready of SKID=0 depends on live inputs.
    task automatic check_all();
        logic v1;
        logic v0;
        v1 = (q1.size() != 0);
        v0 = (q0.size() != 0);
        exp_rdy1 = (q1.size() < 2);
        exp_rdy0 = (q0.size() == 0) || (out_ready && !stall);
        chk("s1_out_valid", {31'd0, out_valid1}, {31'd0, v1});
        chk("s1_count", {30'd0, count1}, q1.size());
        chk("s1_in_ready", {31'd0, in_ready1}, {31'd0, exp_rdy1});
        chk("s1_out_ctrl", {24'd0, out_ctrl1}, v1 ? {24'd0, q1[0].c} : 32'd0);
        if (v1) chk("s1_out_data", {16'd0, out_data1}, {16'd0, q1[0].d});
        chk("s1_cap", {31'd0, (count1 <= 2'd2)}, 32'd1);
        chk("s0_out_valid", {31'd0, out_valid0}, {31'd0, v0});
        chk("s0_count", {30'd0, count0}, q0.size());
        chk("s0_in_ready", {31'd0, in_ready0}, {31'd0, exp_rdy0});
        chk("s0_out_ctrl", {24'd0, out_ctrl0}, v0 ? {24'd0, q0[0].c} : 32'd0);
        if (v0) chk("s0_out_data", {16'd0, out_data0}, {16'd0, q0[0].d});
        chk("s0_cap", {31'd0, (count0 <= 2'd1)}, 32'd1);
    endtask

    // One clock: drive, check, advance the models across the rising edge.
    task automatic cycle(input logic v, input logic [15:0] d, input logic [7:0] c,
                         input logic ordy, input logic st, input logic fl, input logic r);
        ent_t e;
        logic tout;
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        rst       = r;
        #1;
        check_all();
        @(posedge clk);
        e.d = d;
        e.c = c;
        if (r || fl) begin
            q1.delete();
            q0.delete();
        end else begin
            tout = (q1.size() != 0) && ordy && !st;
            if (tout) void'(q1.pop_front());
            if (v && exp_rdy1) q1.push_back(e);
            tout = (q0.size() != 0) && ordy && !st;
            if (tout) void'(q0.pop_front());
            if (v && exp_rdy0) q0.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b1;
        in_data = 16'hBEEF; in_ctrl = 8'hFF; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cycle(1'b1, 16'hBEEF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        chk("rst_data1", {16'd0, out_data1}, 32'd0);
        chk("rst_data0", {16'd0, out_data0}, 32'd0);

        for (int i = 1; i <= 8; i++)
            cycle(1'b1, 16'(i), 8'(8'h10 + i), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        cycle(1'b1, 16'h00A1, 8'h21, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h00A2, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_count", {30'd0, count1}, 32'd2);
        chk("bp_in_ready", {31'd0, in_ready1}, 32'd0);
        chk("bp_head", {16'd0, out_data1}, 32'h00A1);
        cycle(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_second", {16'd0, out_data1}, 32'h00A2);
        cycle(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        cycle(1'b1, 16'h1234, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
            chk("stall_data1", {16'd0, out_data1}, 32'h1234);
            chk("stall_ctrl1", {24'd0, out_ctrl1}, 32'h05);
            chk("stall_data0", {16'd0, out_data0}, 32'h1234);
        end
        cycle(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("unstall_out1", {31'd0, out_valid1}, 32'd0);

        cycle(1'b1, 16'h00B1, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h00B2, 8'h32, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_flush_count", {30'd0, count1}, 32'd2);
        cycle(1'b1, 16'h7777, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("flush_count", {30'd0, count1}, 32'd0);
        chk("flush_ctrl", {24'd0, out_ctrl1}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("no_7777", {31'd0, (out_valid1 && out_data1 == 16'h7777)}, 32'd0);
        end

        cycle(1'b1, 16'h00C1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h00C2, 8'h42, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("rst_flush_data", {16'd0, out_data1}, 32'd0);

        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 3) != 0, 16'($urandom), 8'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
        end
        cycle(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
